// File: rtl/rob_packet_arbiter_pkg.sv
// Shared types for the ROB packet arbiter: ROB index, beat numbering, packet sizes and
// the payload carried by the single-entry output register.
package rob_packet_arbiter_pkg;

    localparam int unsigned robIndexWidth  = 7;
    localparam int unsigned robBeatWidth   = 2;
    localparam int unsigned decPacketBeats = 4;
    localparam int unsigned rruPacketBeats = 2;

    typedef logic [robIndexWidth-1:0] RobIndex_T;
    typedef logic [robBeatWidth-1:0]  RobBeat_T;

    typedef enum logic {
        SrcDec = 1'b0,
        SrcRru = 1'b1
    } RobSrc_T;

    typedef struct packed {
        logic [31:0] data;
        RobSrc_T     src;
        RobBeat_T    beat;
        logic        last;
        RobIndex_T   index;
    } RobBeatPayload_T;

    // The ROB index travels in the top bits of the first beat of every packet.
    function automatic RobIndex_T robIndexOf(input logic [31:0] beatData);
        return beatData[31:25];
    endfunction

endpackage

// File: rtl/rob_packet_arbiter_if.sv
// Bundles the decoder, RRU and ROB beat streams of the arbiter.
// master = the environment around the arbiter, slave = the arbiter itself.
interface rob_packet_arbiter_if;
    import rob_packet_arbiter_pkg::*;

    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_data;

    logic        rru_valid;
    logic        rru_ready;
    logic [31:0] rru_data;

    logic        rob_valid;
    logic        rob_ready;
    logic [31:0] rob_data;
    logic        rob_src;
    RobBeat_T    rob_beat;
    logic        rob_last;
    RobIndex_T   rob_index;

    modport master (
        output dec_valid, dec_data, rru_valid, rru_data, rob_ready,
        input  dec_ready, rru_ready, rob_valid, rob_data, rob_src, rob_beat, rob_last, rob_index
    );

    modport slave (
        input  dec_valid, dec_data, rru_valid, rru_data, rob_ready,
        output dec_ready, rru_ready, rob_valid, rob_data, rob_src, rob_beat, rob_last, rob_index
    );

endinterface

// File: rtl/rob_beat_reg.sv
// Single-entry valid/ready pipeline register holding one ROB beat.
// Accepts a new beat whenever it is empty or being drained in the same cycle.
module rob_beat_reg
    import rob_packet_arbiter_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            inValid,
    output logic            inReady,
    input  RobBeatPayload_T inBeat,
    output logic            outValid,
    input  logic            outReady,
    output RobBeatPayload_T outBeat
);

    assign inReady = !outValid || outReady;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outValid <= 1'b0;
            outBeat  <= '0;
        end else if (inReady) begin
            outValid <= inValid;
            // Payload only moves with a real beat so it stays put once drained.
            if (inValid) begin
                outBeat <= inBeat;
            end
        end
    end

endmodule

// File: rtl/rob_packet_arbiter.sv
// Arbitrates whole decoder and RRU packets onto the shared ROB write channel,
// alternating on contention and never interleaving beats of different packets.
module rob_packet_arbiter
    import rob_packet_arbiter_pkg::*;
#(
    parameter int unsigned DEC_BEATS = decPacketBeats,
    parameter int unsigned RRU_BEATS = rruPacketBeats
) (
    input  logic                 clk,
    input  logic                 rst_n,
    rob_packet_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE,
        DEC_BURST,
        RRU_BURST
    } ArbState_T;

    localparam RobBeat_T decLastBeat = RobBeat_T'(DEC_BEATS - 1);
    localparam RobBeat_T rruLastBeat = RobBeat_T'(RRU_BEATS - 1);

    ArbState_T       state;
    RobBeat_T        beatCnt;
    RobSrc_T         lastGrant;

    logic            regReady;
    logic            beatValid;
    logic [31:0]     payloadData;
    RobBeatPayload_T beatIn;
    RobBeatPayload_T regOut;

    // Only the burst owner sees ready; IDLE is the arbitration bubble.
    always_comb begin
        bus.dec_ready = 1'b0;
        bus.rru_ready = 1'b0;
        case (state)
            DEC_BURST: bus.dec_ready = regReady;
            RRU_BURST: bus.rru_ready = regReady;
            default:   ;
        endcase
    end

    assign beatValid = (bus.dec_valid && bus.dec_ready) || (bus.rru_valid && bus.rru_ready);

    always_comb begin
        payloadData  = (state == RRU_BURST) ? bus.rru_data : bus.dec_data;
        beatIn.data  = payloadData;
        beatIn.src   = (state == RRU_BURST) ? SrcRru : SrcDec;
        beatIn.beat  = beatCnt;
        beatIn.last  = (state == RRU_BURST) ? (beatCnt == rruLastBeat)
                                            : (beatCnt == decLastBeat);
        // Later beats reuse the index already sitting in the output register.
        beatIn.index = (beatCnt == '0) ? robIndexOf(payloadData) : regOut.index;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            beatCnt   <= '0;
            lastGrant <= SrcRru;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.dec_valid && (!bus.rru_valid || lastGrant == SrcRru)) begin
                        state <= DEC_BURST;
                    end else if (bus.rru_valid) begin
                        state <= RRU_BURST;
                    end
                end
                DEC_BURST, RRU_BURST: begin
                    if (beatValid) begin
                        if (beatIn.last) begin
                            beatCnt   <= '0;
                            state     <= IDLE;
                            lastGrant <= beatIn.src;
                        end else begin
                            beatCnt <= beatCnt + RobBeat_T'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    rob_beat_reg u_beatReg (
        .clk      (clk),
        .rst_n    (rst_n),
        .inValid  (beatValid),
        .inReady  (regReady),
        .inBeat   (beatIn),
        .outValid (bus.rob_valid),
        .outReady (bus.rob_ready),
        .outBeat  (regOut)
    );

    assign bus.rob_data  = regOut.data;
    assign bus.rob_src   = regOut.src;
    assign bus.rob_beat  = regOut.beat;
    assign bus.rob_last  = regOut.last;
    assign bus.rob_index = regOut.index;

endmodule

// File: tb/tb_rob_packet_arbiter.sv
// Directed bench for rob_packet_arbiter: queue-fed sources, a ROB-side beat monitor and
// hand-computed expected beat sequences.
module tb_rob_packet_arbiter;
    import rob_packet_arbiter_pkg::*;

    typedef struct {
        logic [31:0] data;
        logic        src;
        logic [1:0]  beat;
        logic        last;
        logic [6:0]  index;
        int          cyc;
    } Capture_T;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rob_packet_arbiter_if bus ();

    rob_packet_arbiter #(
        .DEC_BEATS (4),
        .RRU_BEATS (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int          testCount = 0;
    int          failCount = 0;
    int          cyc = 0;
    logic [31:0] decQ[$];
    logic [31:0] rruQ[$];
    Capture_T    caps[$];
    bit          decEn = 1'b1;
    bit          rruEn = 1'b1;
    bit          robReadyCtl = 1'b1;
    bit          decFire = 1'b0;
    bit          rruFire = 1'b0;

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testCount++;
        if (got !== exp) begin
            failCount++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Sample handshakes mid-cycle, away from the rising edge.
    always @(negedge clk) begin
        decFire = bus.dec_valid && bus.dec_ready;
        rruFire = bus.rru_valid && bus.rru_ready;
        if (bus.rob_valid && bus.rob_ready) begin
            caps.push_back('{bus.rob_data, bus.rob_src, bus.rob_beat, bus.rob_last,
                             bus.rob_index, cyc});
        end
    end

    // Sources and ROB sink update just after each rising edge.
    always @(posedge clk) begin
        cyc++;
        #1;
        if (decFire && decQ.size() > 0) void'(decQ.pop_front());
        if (rruFire && rruQ.size() > 0) void'(rruQ.pop_front());
        bus.dec_valid = decEn && (decQ.size() > 0);
        bus.dec_data  = (decQ.size() > 0) ? decQ[0] : 32'h0;
        bus.rru_valid = rruEn && (rruQ.size() > 0);
        bus.rru_data  = (rruQ.size() > 0) ? rruQ[0] : 32'h0;
        bus.rob_ready = robReadyCtl;
    end

    task automatic waitCaps(input int n, input string tag);
        int k = 0;
        while (caps.size() < n && k < 200) begin
            @(negedge clk);
            k++;
        end
        repeat (4) @(negedge clk);
        checkEq({tag, "_count"}, caps.size(), n);
    endtask

    task automatic checkCap(input int i, input string tag, input logic [31:0] data,
                            input logic src, input logic [1:0] beat, input logic last,
                            input logic [6:0] index);
        string t;
        t = $sformatf("%s_%0d", tag, i);
        if (i >= caps.size()) begin
            checkEq({t, "_present"}, 32'(caps.size()), 32'(i + 1));
            return;
        end
        checkEq({t, "_data"}, caps[i].data, data);
        checkEq({t, "_src"}, caps[i].src, src);
        checkEq({t, "_beat"}, caps[i].beat, beat);
        checkEq({t, "_last"}, caps[i].last, last);
        checkEq({t, "_index"}, caps[i].index, index);
    endtask

    task automatic doReset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        caps.delete();
        decQ.delete();
        rruQ.delete();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int k;
        repeat (3) @(negedge clk);
        checkEq("rst_rob_valid", bus.rob_valid, 0);
        checkEq("rst_rob_data", bus.rob_data, 0);
        checkEq("rst_rob_beat", bus.rob_beat, 0);
        checkEq("rst_rob_last", bus.rob_last, 0);
        checkEq("rst_rob_index", bus.rob_index, 0);
        checkEq("rst_dec_ready", bus.dec_ready, 0);
        checkEq("rst_rru_ready", bus.rru_ready, 0);
        rst_n = 1'b1;

        // Decoder alone, full throughput.
        @(negedge clk);
        for (int i = 0; i < 4; i++) decQ.push_back(32'h0A000001 + 32'(i));
        waitCaps(4, "t1");
        for (int i = 0; i < 4; i++) checkCap(i, "t1", 32'h0A000001 + 32'(i), 1'b0, 2'(i), i == 3, 7'h05);
        if (caps.size() >= 4) checkEq("t1_throughput", caps[3].cyc - caps[0].cyc, 3);

        // Both valid from reset: decoder wins first, then alternation.
        doReset();
        for (int i = 0; i < 4; i++) decQ.push_back(32'h0A000001 + 32'(i));
        for (int i = 0; i < 4; i++) decQ.push_back(32'h0E000031 + 32'(i));
        rruQ.push_back(32'h14000011);
        rruQ.push_back(32'h14000012);
        rruQ.push_back(32'h16000021);
        rruQ.push_back(32'h16000022);
        waitCaps(12, "t2");
        for (int i = 0; i < 4; i++) checkCap(i, "t2", 32'h0A000001 + 32'(i), 1'b0, 2'(i), i == 3, 7'h05);
        checkCap(4, "t2", 32'h14000011, 1'b1, 2'd0, 1'b0, 7'h0A);
        checkCap(5, "t2", 32'h14000012, 1'b1, 2'd1, 1'b1, 7'h0A);
        for (int i = 0; i < 4; i++) checkCap(6 + i, "t2", 32'h0E000031 + 32'(i), 1'b0, 2'(i), i == 3, 7'h07);
        checkCap(10, "t2", 32'h16000021, 1'b1, 2'd0, 1'b0, 7'h0B);
        checkCap(11, "t2", 32'h16000022, 1'b1, 2'd1, 1'b1, 7'h0B);
        if (caps.size() >= 5) checkEq("t2_bubble", caps[4].cyc - caps[3].cyc, 2);

        // ROB stalls for three cycles while beat 2 is presented.
        caps.delete();
        for (int i = 0; i < 4; i++) decQ.push_back(32'h0C000001 + 32'(i));
        k = 0;
        while (!(bus.rob_valid && bus.rob_beat == 2'd1) && k < 100) begin
            @(negedge clk);
            k++;
        end
        checkEq("t3_wait_beat1", k < 100, 1);
        robReadyCtl = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkEq($sformatf("t3_hold_valid_%0d", i), bus.rob_valid, 1);
            checkEq($sformatf("t3_hold_data_%0d", i), bus.rob_data, 32'h0C000003);
            checkEq($sformatf("t3_hold_beat_%0d", i), bus.rob_beat, 2);
            checkEq($sformatf("t3_dec_ready_%0d", i), bus.dec_ready, 0);
        end
        robReadyCtl = 1'b1;
        waitCaps(4, "t3");
        for (int i = 0; i < 4; i++) checkCap(i, "t3", 32'h0C000001 + 32'(i), 1'b0, 2'(i), i == 3, 7'h06);

        // RRU granted (decoder went last), then drops valid after beat 0.
        caps.delete();
        rruQ.push_back(32'h18000041);
        rruQ.push_back(32'h18000042);
        for (int i = 0; i < 4; i++) decQ.push_back(32'h1A000051 + 32'(i));
        k = 0;
        while (!(bus.rru_valid && bus.rru_ready) && k < 100) begin
            @(negedge clk);
            k++;
        end
        checkEq("t4_wait_rru", k < 100, 1);
        rruEn = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkEq($sformatf("t4_dec_ready_%0d", i), bus.dec_ready, 0);
            checkEq($sformatf("t4_rru_ready_%0d", i), bus.rru_ready, 1);
        end
        rruEn = 1'b1;
        waitCaps(6, "t4");
        checkCap(0, "t4", 32'h18000041, 1'b1, 2'd0, 1'b0, 7'h0C);
        checkCap(1, "t4", 32'h18000042, 1'b1, 2'd1, 1'b1, 7'h0C);
        for (int i = 0; i < 4; i++) checkCap(2 + i, "t4", 32'h1A000051 + 32'(i), 1'b0, 2'(i), i == 3, 7'h0D);

        // Reset mid-packet discards it; the next packet starts cleanly at beat 0.
        caps.delete();
        for (int i = 0; i < 4; i++) decQ.push_back(32'h1C000061 + 32'(i));
        k = 0;
        while (!(bus.rob_valid && bus.rob_beat == 2'd1) && k < 100) begin
            @(negedge clk);
            k++;
        end
        checkEq("t5_wait_beat1", k < 100, 1);
        rst_n = 1'b0;
        #1;
        checkEq("t5_rob_valid", bus.rob_valid, 0);
        checkEq("t5_rob_data", bus.rob_data, 0);
        checkEq("t5_rob_src", bus.rob_src, 0);
        checkEq("t5_rob_beat", bus.rob_beat, 0);
        checkEq("t5_rob_last", bus.rob_last, 0);
        checkEq("t5_rob_index", bus.rob_index, 0);
        checkEq("t5_dec_ready", bus.dec_ready, 0);
        decQ.delete();
        caps.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        checkEq("t5_no_stray", caps.size(), 0);
        rruQ.push_back(32'h1E000071);
        rruQ.push_back(32'h1E000072);
        waitCaps(2, "t5");
        checkCap(0, "t5", 32'h1E000071, 1'b1, 2'd0, 1'b0, 7'h0F);
        checkCap(1, "t5", 32'h1E000072, 1'b1, 2'd1, 1'b1, 7'h0F);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
